// File: rtl/led_pwm_pkg.sv
// Shared helpers for the LED PWM port: period length, counter widths and
// channel field placement inside the CPU port word.
package led_pwm_pkg;

   // Direction of the per-boundary duty step when fading is built in.
   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2
   } step_dir_e;

   // Number of PWM ticks in one period; also the duty value meaning "always on".
   function automatic int pwm_max(input int bright_bits);
      return (32'sd1 <<< bright_bits) - 32'sd1;
   endfunction

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clog2_min1(input int value);
      int w;
      w = 32'sd1;
      while ((32'sd1 <<< w) < value) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

   // LSB position of a channel's duty field inside the port word.
   function automatic int field_lsb(input int ch, input int bright_bits);
      return ch * bright_bits;
   endfunction

endpackage

// File: rtl/led_pwm_port_tick_gen.sv
// Shared timebase for all LED channels: a prescaler producing the PWM tick
// and the PWM counter that walks 0..MAX-1. The boundary output marks the
// last tick of a period, where new duties are taken.
module pwm_tick_gen
   import led_pwm_pkg::*;
#(
   parameter int BRIGHT_BITS = 8,
   parameter int PRESCALE    = 64
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   output logic                   o_tick,
   output logic [BRIGHT_BITS-1:0] o_pwm_cnt,
   output logic                   o_boundary
);

   localparam int PS_W  = clog2_min1(PRESCALE);
   localparam int MAX_C = pwm_max(BRIGHT_BITS);
   localparam logic [PS_W-1:0]        PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [BRIGHT_BITS-1:0] CNT_LAST = BRIGHT_BITS'(MAX_C - 1);

   logic [PS_W-1:0]        r_presc;
   logic [BRIGHT_BITS-1:0] r_cnt;
   logic                   w_tick;
   logic                   w_cnt_last;

   assign w_tick     = (r_presc == PS_LAST);
   assign w_cnt_last = (r_cnt == CNT_LAST);

   // Prescaler: count clk cycles and wrap after the tick cycle.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PS_W'(1);
      end
   end

   // PWM counter: advance once per tick, wrapping at MAX-1 so MAX is never reached.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         if (w_cnt_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + BRIGHT_BITS'(1);
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_tick     = w_tick;
   assign o_pwm_cnt  = r_cnt;
   assign o_boundary = w_tick && w_cnt_last;

endmodule

// File: rtl/led_pwm_port.sv
// LED PWM output port: turns the CPU port word into NUM_LED PWM-dimmed LED
// pins. Duties change only at period boundaries so a pin never glitches
// mid-period. Optional macro LED_PWM_FADE_EN makes each duty walk one step
// per period toward its target instead of jumping.
module led_pwm_port
   import led_pwm_pkg::*;
#(
   parameter int WIDTH_REG   = 32,
   parameter int NUM_LED     = 3,
   parameter int BRIGHT_BITS = 8,
   parameter int PRESCALE    = 64,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH_REG-1:0] port_out,
   output logic [NUM_LED-1:0]   led,
   output logic [WIDTH_REG-1:0] status,
   output logic                 period_pulse,
   output logic                 fade_busy
);

   localparam logic LED_OFF = (ACTIVE_LOW != 0);

   logic                   w_tick;
   logic                   w_boundary;
   logic [BRIGHT_BITS-1:0] w_pwm_cnt;
   logic [BRIGHT_BITS-1:0] w_duty      [NUM_LED];
   logic [BRIGHT_BITS-1:0] w_duty_next [NUM_LED];
   logic [NUM_LED-1:0]     w_lit;
   logic [WIDTH_REG-1:0]   w_status_next;
   logic                   w_unused_bits;

   logic [NUM_LED-1:0]     r_led;
   logic [WIDTH_REG-1:0]   r_status;
   logic                   r_pulse;

   // Upper port bits and the raw tick are not needed beyond the timebase.
   assign w_unused_bits = ^{port_out, w_tick};

   pwm_tick_gen #(
      .BRIGHT_BITS (BRIGHT_BITS),
      .PRESCALE    (PRESCALE)
   ) u_tick_gen (
      .i_clk      (clk),
      .i_reset    (reset),
      .o_tick     (w_tick),
      .o_pwm_cnt  (w_pwm_cnt),
      .o_boundary (w_boundary)
   );

`ifdef LED_PWM_FADE_EN
   logic [NUM_LED-1:0] w_differs;
   logic               r_busy;
`endif

   for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
      logic [BRIGHT_BITS-1:0] w_target;
      logic [BRIGHT_BITS-1:0] w_next;
      logic [BRIGHT_BITS-1:0] r_duty;

      assign w_target = port_out[field_lsb(g, BRIGHT_BITS) +: BRIGHT_BITS];

`ifdef LED_PWM_FADE_EN
      step_dir_e w_dir;

      // Decide which way this channel's duty should move at the boundary.
      always_comb begin
         w_dir = STEP_HOLD;
         if (r_duty < w_target) begin
            w_dir = STEP_UP;
         end else if (r_duty > w_target) begin
            w_dir = STEP_DOWN;
         end else begin
            w_dir = STEP_HOLD;
         end
      end

      // Single-step toward the target so brightness ramps over many periods.
      always_comb begin
         w_next = r_duty;
         case (w_dir)
            STEP_UP:   w_next = r_duty + BRIGHT_BITS'(1);
            STEP_DOWN: w_next = r_duty - BRIGHT_BITS'(1);
            STEP_HOLD: w_next = r_duty;
            default:   w_next = r_duty;
         endcase
      end

      assign w_differs[g] = (r_duty != w_target);
`else
      assign w_next = w_target;
`endif

      // Active duty: only replaced at the period boundary to avoid glitches.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_duty <= '0;
         end else if (w_boundary) begin
            r_duty <= w_next;
         end else begin
            r_duty <= r_duty;
         end
      end

      assign w_duty[g]      = r_duty;
      assign w_duty_next[g] = w_next;
      assign w_lit[g]       = (w_pwm_cnt < r_duty);
   end

   // Pack the duties that will be active after the boundary into status layout.
   always_comb begin
      w_status_next = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         w_status_next[field_lsb(i, BRIGHT_BITS) +: BRIGHT_BITS] = w_duty_next[i];
      end
   end

   // LED pins: registered compare result with board polarity applied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led <= {NUM_LED{LED_OFF}};
      end else begin
         r_led <= w_lit ^ {NUM_LED{LED_OFF}};
      end
   end

   // Period strobe and status copy, both visible in the cycle after the boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pulse  <= 1'b0;
         r_status <= '0;
      end else begin
         r_pulse <= w_boundary;
         if (w_boundary) begin
            r_status <= w_status_next;
         end else begin
            r_status <= r_status;
         end
      end
   end

`ifdef LED_PWM_FADE_EN
   // Busy while any channel is still ramping toward its target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= |w_differs;
      end
   end

   assign fade_busy = r_busy;
`else
   assign fade_busy = 1'b0;
`endif

   assign led          = r_led;
   assign status       = r_status;
   assign period_pulse = r_pulse;

endmodule

// File: tb/tb_led_pwm_port.sv
// Self-checking bench for led_pwm_port (BRIGHT_BITS=4, NUM_LED=3, ACTIVE_LOW=1).
// A second instance with PRESCALE=4 is used for period counting.
module tb_led_pwm_port;

   localparam int BB   = 4;
   localparam int NL   = 3;
   localparam int P1   = 1;
   localparam int P2   = 4;
   localparam int MAXV = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] port_out;

   logic [2:0]  led1, led2;
   logic [31:0] status1, status2;
   logic        pulse1, pulse2, busy1, busy2;

   int checks = 0;
   int errors = 0;

   // reference model state: cycles since reset release and active duties
   int          t;
   int          m_duty [NL];
   logic [2:0]  e_led;
   logic [31:0] e_status;
   logic        e_pulse;
   logic        e_busy;

   led_pwm_port #(.WIDTH_REG(32), .NUM_LED(NL), .BRIGHT_BITS(BB), .PRESCALE(P1), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .reset(reset), .port_out(port_out), .led(led1),
      .status(status1), .period_pulse(pulse1), .fade_busy(busy1));

   led_pwm_port #(.WIDTH_REG(32), .NUM_LED(NL), .BRIGHT_BITS(BB), .PRESCALE(P2), .ACTIVE_LOW(1)) dut2 (
      .clk(clk), .reset(reset), .port_out(port_out), .led(led2),
      .status(status2), .period_pulse(pulse2), .fade_busy(busy2));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pout;
      logic [31:0] e_stat;
      int          lows [NL];
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int tgt(input logic [31:0] pout, input int i);
      return int'((pout >> (BB * i)) & 32'hF);
   endfunction

   task automatic model_reset();
      t = 0;
      for (int i = 0; i < NL; i++) m_duty[i] = 0;
      e_led    = 3'b111;
      e_status = 32'h0;
      e_pulse  = 1'b0;
      e_busy   = 1'b0;
   endtask

   // one clock: advance the model from arithmetic on elapsed time, then compare
   task automatic step();
      int cnt;
      bit tick, bnd, busy;
      @(posedge clk);
      cnt  = (t / P1) % MAXV;
      tick = ((t % P1) == P1 - 1);
      bnd  = tick && (cnt == MAXV - 1);
      busy = 1'b0;
      for (int i = 0; i < NL; i++) begin
         e_led[i] = !(cnt < m_duty[i]);
         if (m_duty[i] != tgt(port_out, i)) busy = 1'b1;
      end
      if (bnd) begin
         e_status = 32'h0;
         for (int i = 0; i < NL; i++) begin
`ifdef LED_PWM_FADE_EN
            if (m_duty[i] < tgt(port_out, i)) m_duty[i]++;
            else if (m_duty[i] > tgt(port_out, i)) m_duty[i]--;
`else
            m_duty[i] = tgt(port_out, i);
`endif
            e_status = e_status | (32'(m_duty[i]) << (BB * i));
         end
      end
      e_pulse = bnd;
`ifdef LED_PWM_FADE_EN
      e_busy = busy;
`else
      e_busy = 1'b0;
`endif
      t++;
      #1;
      chk("model_led",    {29'h0, led1},   {29'h0, e_led});
      chk("model_status", status1,         e_status);
      chk("model_pulse",  {31'h0, pulse1}, {31'h0, e_pulse});
      chk("model_busy",   {31'h0, busy1},  {31'h0, e_busy});
   endtask

   task automatic wait_pulse();
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!pulse1 && n < 40);
      chk("pulse_timeout", {31'h0, pulse1}, 32'h1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_led1",    {29'h0, led1},   32'h7);
      chk("rst_led2",    {29'h0, led2},   32'h7);
      chk("rst_status",  status1,         32'h0);
      chk("rst_pulse",   {31'h0, pulse1}, 32'h0);
      chk("rst_busy",    {31'h0, busy1},  32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      vec_t tbl [4];
      int   lows [NL];
      int   np1, np2, dbl;
      bit   prev;

      tbl[0].pout = 32'h0F5; tbl[0].e_stat = 32'h0F5; tbl[0].lows = '{5, 15, 0};
      tbl[1].pout = 32'h37F; tbl[1].e_stat = 32'h37F; tbl[1].lows = '{15, 7, 3};
      tbl[2].pout = 32'h000; tbl[2].e_stat = 32'h000; tbl[2].lows = '{0, 0, 0};
      tbl[3].pout = 32'hAB9A1; tbl[3].e_stat = 32'h9A1; tbl[3].lows = '{1, 10, 9};

      reset    = 1'b1;
      port_out = 32'hFFF;
      model_reset();
      repeat (2) @(negedge clk);
      chk("hold_led",    {29'h0, led1},   32'h7);
      chk("hold_status", status1,         32'h0);
      chk("hold_pulse",  {31'h0, pulse1}, 32'h0);
      reset = 1'b0;

`ifdef LED_PWM_FADE_EN
      // fade ramp: ch0 target 0 -> 3
      port_out = 32'h0;
      do_reset();
      repeat (3) step();
      port_out = 32'h003;
      step();
      chk("fade_busy_rise", {31'h0, busy1}, 32'h1);
      wait_pulse();
      chk("fade_s1", status1, 32'h1);
      wait_pulse();
      chk("fade_s2", status1, 32'h2);
      wait_pulse();
      chk("fade_s3", status1, 32'h3);
      chk("fade_busy_at3", {31'h0, busy1}, 32'h1);
      step();
      chk("fade_busy_fall", {31'h0, busy1}, 32'h0);
`else
      // first boundary after release
      repeat (15) step();
      chk("first_pulse",  {31'h0, pulse1}, 32'h1);
      chk("first_status", status1,         32'hFFF);
      step();
      chk("first_led_on", {29'h0, led1},   32'h0);

      // duty table: count lit (low) cycles over one full period
      for (int v = 0; v < 4; v++) begin
         port_out = tbl[v].pout;
         wait_pulse();
         chk("tbl_status", status1, tbl[v].e_stat);
         for (int i = 0; i < NL; i++) lows[i] = 0;
         for (int c = 0; c < MAXV; c++) begin
            step();
            for (int i = 0; i < NL; i++) if (led1[i] == 1'b0) lows[i]++;
         end
         for (int i = 0; i < NL; i++) chk("tbl_lows", 32'(lows[i]), 32'(tbl[v].lows[i]));
      end

      // mid-period rewrite: only the value present at the boundary counts
      wait_pulse();
      port_out = 32'h003;
      repeat (3) step();
      port_out = 32'h00A;
      wait_pulse();
      chk("discard_status", status1, 32'h00A);

      // asynchronous reset mid-period with duty 9 at pwm_cnt 7
      port_out = 32'h009;
      wait_pulse();
      repeat (7) step();
      chk("pre_rst_lit", {31'h0, led1[0]}, 32'h0);
      reset = 1'b1;
      #1;
      chk("async_led",    {29'h0, led1},   32'h7);
      chk("async_status", status1,         32'h0);
      #2;
      reset = 1'b0;
      model_reset();
      repeat (14) step();
      chk("restart_nopulse", {31'h0, pulse1}, 32'h0);
      step();
      chk("restart_pulse",  {31'h0, pulse1}, 32'h1);
      chk("restart_status", status1,         32'h009);
`endif

      // period counting on both prescale settings
      do_reset();
      np1 = 0; np2 = 0; dbl = 0; prev = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         step();
         if (k <= 150 && pulse1) np1++;
         if (pulse2) np2++;
         if (pulse1 && prev) dbl++;
         prev = pulse1;
      end
      chk("pulses_p1",   32'(np1), 32'd10);
      chk("pulses_p4",   32'(np2), 32'd10);
      chk("pulse_width", 32'(dbl), 32'd0);

      // randomized traffic against the model
      do_reset();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 5) == 0) port_out = $urandom;
         if (k == 200 && $urandom_range(0, 1) == 1) do_reset();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pwm_port.md
Name: led_pwm_port

Overview:
- Parametrised successor to the plain inverted-LED hookup on the CPU output port.
- Takes the CPU `port_out` word and drives NUM_LED LED pins. Each LED gets its own PWM brightness field.
- Duty updates are glitch-free (applied only at period boundaries), with selectable pin polarity and a prescaled PWM clock.
- Sits between `sc1_cpu.port_out` and the board LED pins; `status` is suitable for wiring back to `port_in`.

Parameters:
- WIDTH_REG, 32, width of the CPU port word.
- NUM_LED, 3, number of LED channels.
- BRIGHT_BITS, 8, duty field width per channel. Must satisfy NUM_LED*BRIGHT_BITS <= WIDTH_REG.
- PRESCALE, 64, clk cycles per PWM tick. Must be >= 1.
- ACTIVE_LOW, 1, 1 means a pin is driven 0 when the LED is lit.

Ports:
- clk  in  1  system clock (single clock domain).
- reset  in  1  asynchronous, active-high reset.
- port_out  in  WIDTH_REG  CPU port word. Channel i duty target = port_out[BRIGHT_BITS*i +: BRIGHT_BITS]. Upper bits ignored.
- led  out  NUM_LED  LED pins, polarity per ACTIVE_LOW.
- status  out  WIDTH_REG  packed active duties, same layout as port_out, zero-extended.
- period_pulse  out  1  one-cycle strobe at each PWM period boundary.
- fade_busy  out  1  high while any active duty differs from its target. Tied 0 without FADE_EN.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high; all flops clear on its assertion, independent of clk.
- Reset values:
  - led = {NUM_LED{ACTIVE_LOW}} (all off)
  - status = 0, period_pulse = 0, fade_busy = 0
  - prescaler = 0, pwm_cnt = 0, duty_active[*] = 0
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = 1 in the cycle where prescaler == PRESCALE-1.
  - PRESCALE = 1 gives tick every cycle.
- PWM counter:
  - pwm_cnt, BRIGHT_BITS wide, advances on tick over 0..MAX-1, where MAX = 2^BRIGHT_BITS-1.
  - On tick at MAX-1 it wraps to 0. Period = MAX ticks.
- Boundary event:
  - Defined as tick && pwm_cnt == MAX-1.
  - On it, each duty_active[i] loads its target (without FADE_EN).
  - period_pulse is registered high for exactly the following cycle.
- Output compare:
  - lit_i = (pwm_cnt < duty_active[i]).
  - led[i] <= lit_i ^ ACTIVE_LOW, registered, so one cycle latency from pwm_cnt.
  - duty 0 is always off. Duty MAX is always on, since pwm_cnt never reaches MAX.
- Update latency: a port_out change mid-period has no effect until the next boundary. Only the value sampled in the boundary cycle is used; intermediate values are discarded.
- status: registered copy of duty_active, updated the cycle after the boundary.
- Reset mid-period: everything returns to reset values immediately. After release the counters restart from 0 and duty stays 0 until the first boundary.
- Simultaneous port_out change in the boundary cycle: the new value is taken.

Optional Feature:
- Macro LED_PWM_FADE_EN.
- Defined:
  - At each boundary, duty_active[i] steps by 1 toward its target (+1 if below, -1 if above, hold if equal). A full-scale swing therefore takes MAX periods.
  - fade_busy = OR over i of (duty_active[i] != target_i), registered.
- Undefined:
  - Immediate load at the boundary.
  - fade_busy constant 0; no fade comparators synthesised.

Decomposition:
- Package led_pwm_pkg:
  - function for MAX from BRIGHT_BITS
  - clog2 helper for prescaler width
  - field-extract function (channel index -> bit offset)
- Sub-module pwm_tick_gen:
  - prescaler plus pwm_cnt
  - outputs tick, pwm_cnt, boundary
  - reused for all channels
- Per-channel duty/compare logic lives in a generate loop in the parent.

Test Plan (BRIGHT_BITS=4, PRESCALE=1, NUM_LED=3, ACTIVE_LOW=1, MAX=15):
- Reset held, port_out=0xFFF -> led=3'b111, status=0, period_pulse=0. Release -> first boundary at cycle 15 after release; status=0x00000FFF the cycle after; led=3'b000 thereafter.
- port_out=0x0F5 (ch0=5, ch1=15, ch2=0) -> per 15-cycle period: led[0] low 5 cycles then high 10; led[1] constantly low; led[2] constantly high.
- Write port_out=0x003 then 0x00A within one period -> the 0x003 value never appears; the next period uses duty 10; status=0x00A.
- Assert reset at pwm_cnt=7 with duty 9 -> led returns to 3'b111 asynchronously (before the next clk edge); counters restart at 0 on release.
- period_pulse: count pulses over 150 cycles -> exactly 10, each one cycle wide. With PRESCALE=4 -> exactly 10 pulses over 600 cycles.
- LED_PWM_FADE_EN, ch0 target changed 0 -> 3 -> status ch0 goes 1, 2, 3 on successive boundaries. fade_busy is high from the cycle after the target changes until the cycle after status reaches 3.
